clmul_seq: RTL and testbench
============================

CLMUL_SEQ -- requirements
Module: clmul_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter DIGIT, default 2, giving the multiplier bits consumed per cycle; DIGIT SHALL divide WIDTH exactly.
REQ-003 The block SHALL define a derived constant CYCLES = WIDTH/DIGIT.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 a  input  WIDTH  multiplicand polynomial over GF(2).
REQ-010 b  input  WIDTH  multiplier polynomial over GF(2).
REQ-011 mode  input  1  0 = full carryless product; 1 = product reduced modulo P.
REQ-012 poly  input  WIDTH  low coefficients of P; x^WIDTH is implicit.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 y  output  2*WIDTH-1  result.

Function
REQ-016 y[k] SHALL equal the XOR over all i+j=k of a[i]&b[j], with no carries, when mode=0.
REQ-017 When mode=1, y[WIDTH-1:0] SHALL equal (a*b) mod (x^WIDTH + poly) over GF(2), and y[2*WIDTH-2:WIDTH] SHALL be 0.
REQ-018 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 A request is accepted at a rising edge where in_valid=1 and in_ready=1; at that edge a, b, mode and poly SHALL be captured, and the FSM SHALL go to BUSY.
REQ-021 Input changes after acceptance SHALL NOT affect the result.
REQ-022 In BUSY, the block SHALL consume DIGIT bits of b per cycle, MSB-first, and SHALL apply reduction every step when mode=1.
REQ-023 The FSM SHALL leave BUSY after exactly CYCLES cycles.
REQ-024 out_valid SHALL rise on the edge CYCLES cycles after the accept edge (DONE state); latency is fixed and independent of the operand values.
REQ-025 In DONE, out_valid=1, and y SHALL stay stable until a rising edge with out_ready=1, which returns the FSM to IDLE.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 in_valid SHALL be ignored outside IDLE.
REQ-028 No request SHALL be accepted in the cycle a result is consumed; maximum throughput is one result per CYCLES+2 cycles.
REQ-029 The operands a=0 or b=0 SHALL give y=0 with the normal latency.
REQ-030 When mode=1 with poly=0, the result SHALL reduce modulo x^WIDTH, giving the low WIDTH bits of the full product.
REQ-031 When DIGIT=WIDTH, the block SHALL operate with CYCLES=1.

Reset
REQ-032 While rst=1 at a rising edge, the FSM SHALL go to IDLE, and in_ready SHALL be 1, out_valid 0 and y 0 from the next cycle.
REQ-033 Reset in BUSY or DONE SHALL discard the operation in progress and produce no out_valid pulse.
REQ-034 An in_valid present on the same edge as rst=1 SHALL NOT be accepted.

Verification
REQ-035 WIDTH=8, DIGIT=2, mode=0, a=0x03, b=0x03 -> out_valid 4 cycles after accept; y=0x0005.
REQ-036 WIDTH=8, DIGIT=2, mode=0, a=0xFF, b=0xFF -> y=0x5555; 1000 random a/b SHALL match a bitwise GF(2) reference model.
REQ-037 WIDTH=8, mode=1, poly=0x1B: a=0x57, b=0x83 -> y=0x00C1; a=0x57, b=0x13 -> y=0x00FE.
REQ-038 Hold out_ready=0 for 10 cycles in DONE, toggling in_valid and changing a -> y stable, in_ready=0, no extra accept; out_ready=1 -> IDLE next cycle.
REQ-039 Assert rst in the 2nd BUSY cycle -> in_ready=1 next cycle, out_valid never rises; a new request then completes with the correct value.
REQ-040 Sweep DIGIT in {1,2,4,8} with WIDTH=8 and WIDTH=16 -> latency equals WIDTH/DIGIT and results match the reference model in both modes.

Source files
------------

// File: rtl/clmul_seq_if.sv
// Request/result handshake bundle for the sequential carryless multiplier.
// The master drives requests and the consumer's ready; the slave returns the result.
interface clmul_seq_if #(
   parameter int WIDTH = 8
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 mode;
   logic [WIDTH-1:0]     poly;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-2:0]   y;

   modport master (
      output in_valid, a, b, mode, poly, out_ready,
      input  in_ready, out_valid, y
   );

   modport slave (
      input  in_valid, a, b, mode, poly, out_ready,
      output in_ready, out_valid, y
   );
endinterface

// File: rtl/clmul_seq.sv
// Digit-serial GF(2) multiplier: consumes DIGIT bits of b per cycle, MSB first,
// returning either the full carryless product or the product reduced modulo x^WIDTH + poly.
module clmul_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   clmul_seq_if.slave  bus
);
   localparam int CYCLES = WIDTH / DIGIT;
   localparam int YW     = 2 * WIDTH - 1;
   localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES - 1);
   localparam logic [YW-1:0] LOW_MASK = {{(WIDTH-1){1'b0}}, {WIDTH{1'b1}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  poly_q, poly_d;
   logic              mode_q, mode_d;
   logic [YW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [YW-1:0]     y_q, y_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [YW-1:0]     step_s;

   // One Horner step per multiplier bit: acc = acc*x (+ reduction) then add a when the bit is set.
   // In reduced mode acc never exceeds WIDTH bits, so the bit shifted out of position WIDTH-1
   // is folded back through poly.
   function automatic logic [YW-1:0] step_f(
      input logic [YW-1:0]    acc,
      input logic [WIDTH-1:0] op_a,
      input logic [DIGIT-1:0] dig,
      input logic             red,
      input logic [WIDTH-1:0] p
   );
      logic [YW-1:0] r;
      logic [YW-1:0] a_ext;
      logic [YW-1:0] p_ext;
      logic          top;
      a_ext = {{(WIDTH-1){1'b0}}, op_a};
      p_ext = {{(WIDTH-1){1'b0}}, p};
      r     = acc;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         top = r[WIDTH-1];
         r   = {r[YW-2:0], 1'b0};
         if (red) begin
            r = r & LOW_MASK;
            if (top) begin
               r = r ^ p_ext;
            end else begin
               r = r;
            end
         end else begin
            r = r;
         end
         if (dig[i]) begin
            r = r ^ a_ext;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Datapath step for the digit currently at the top of the multiplier register.
   always_comb begin
      step_s = step_f(acc_q, a_q, b_q[WIDTH-1 -: DIGIT], mode_q, poly_q);
   end

   // Next-state and datapath control for the IDLE/BUSY/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      poly_d      = poly_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      y_d         = y_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               poly_d  = bus.poly;
               mode_d  = bus.mode;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            acc_d = step_s;
            b_d   = b_q << DIGIT;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               y_d     = step_s;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = BUSY;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         poly_q      <= '0;
         mode_q      <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         y_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         poly_q      <= poly_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
endmodule

// File: tb/tb_clmul_seq.sv
// Scoreboard bench for clmul_seq: directed and random checks on an 8-bit/2-digit instance
// plus a WIDTH x DIGIT sweep of independent instances against a long-division GF(2) model.
module tb_clmul_seq;
   localparam int W   = 8;
   localparam int CYC = 4;

   logic clk = 1'b0;
   logic rst;
   logic sw_rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   main_acc_cyc = 0;
   logic prev_ov = 1'b0;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   clmul_seq_if #(.WIDTH(W)) mbus ();

   clmul_seq #(.WIDTH(W), .DIGIT(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (mbus)
   );

   task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: schoolbook carryless product, then long division by x^w + poly.
   function automatic logic [127:0] ref_f(input logic [63:0] ra, input logic [63:0] rb,
                                          input logic [63:0] rp, input int w, input bit md);
      logic [127:0] p;
      p = '0;
      for (int i = 0; i < w; i++)
         for (int j = 0; j < w; j++)
            p[i+j] = p[i+j] ^ (ra[i] & rb[j]);
      if (md) begin
         for (int k = 2*w - 2; k >= w; k--) begin
            if (p[k]) begin
               p[k] = 1'b0;
               p = p ^ ({64'd0, rp} << (k - w));
            end
         end
      end
      return p;
   endfunction

   // Main-instance monitor: latency on each rising out_valid, result on each handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (mbus.out_valid && !prev_ov)
            chk_eq("latency", 128'(cyc - main_acc_cyc), 128'(CYC));
         if (mbus.out_valid && mbus.out_ready) begin
            if (exp_q.size() == 0) chk_eq("spurious_out", 128'd1, 128'd0);
            else chk_eq("y", 128'(mbus.y), exp_q.pop_front());
         end
      end
      prev_ov <= mbus.out_valid;
   end

   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                       input logic [7:0] tp, input logic [127:0] texp);
      int n = 0;
      while (!mbus.in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!mbus.in_ready) chk_eq("ready_timeout", 128'd0, 128'd1);
      mbus.a = ta; mbus.b = tb; mbus.mode = tm; mbus.poly = tp; mbus.in_valid = 1'b1;
      exp_q.push_back(texp);
      @(posedge clk); #1;
      main_acc_cyc = cyc;
      mbus.in_valid = 1'b0;
      // scramble operands to show they were captured
      mbus.a = 8'($urandom); mbus.b = 8'($urandom); mbus.mode = ~tm; mbus.poly = 8'($urandom);
   endtask

   task automatic wait_res();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (exp_q.size() != 0) begin
         chk_eq("result_timeout", 128'd1, 128'd0);
         exp_q.delete();
      end
   endtask

   task automatic send_ref(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                           input logic [7:0] tp);
      send(ta, tb, tm, tp, ref_f(64'(ta), 64'(tb), 64'(tp), W, tm));
      wait_res();
   endtask

   // Sweep: independent instances over WIDTH in {8,16} and DIGIT in {1,2,4,8}.
   for (genvar g = 0; g < 8; g++) begin : g_sw
      localparam int SW = (g < 4) ? 8 : 16;
      localparam int SD = 1 << (g % 4);
      localparam int SC = SW / SD;
      clmul_seq_if #(.WIDTH(SW)) sbus ();
      clmul_seq #(.WIDTH(SW), .DIGIT(SD)) u_sw (
         .clk (clk),
         .rst (sw_rst),
         .bus (sbus)
      );
      logic [127:0] sq[$];
      bit done_b = 1'b0;
      initial begin
         logic [63:0] ra, rb, rp, msk;
         bit rm;
         int acc_c, n;
         msk = (64'd1 << SW) - 64'd1;
         sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0; sbus.mode = 1'b0;
         sbus.poly = '0; sbus.out_ready = 1'b1;
         repeat (5) @(posedge clk);
         #1;
         for (int t = 0; t < 60; t++) begin
            ra = {$urandom, $urandom} & msk;
            rb = {$urandom, $urandom} & msk;
            rp = {$urandom, $urandom} & msk;
            rm = t[0];
            sbus.a = ra[SW-1:0]; sbus.b = rb[SW-1:0]; sbus.poly = rp[SW-1:0];
            sbus.mode = rm; sbus.in_valid = 1'b1;
            sq.push_back(ref_f(ra, rb, rp, SW, rm));
            @(posedge clk); #1;
            acc_c = cyc;
            sbus.in_valid = 1'b0;
            n = 0;
            while (!sbus.out_valid && n < 100) begin
               @(posedge clk); #1; n++;
            end
            chk_eq($sformatf("sw%0d_latency", g), 128'(cyc - acc_c), 128'(SC));
            chk_eq($sformatf("sw%0d_y", g), 128'(sbus.y), sq.pop_front());
            @(posedge clk); #1;
         end
         done_b = 1'b1;
      end
   end

   initial begin
      logic [7:0] ra, rb, rp;
      int n;
      rst = 1'b1; sw_rst = 1'b1;
      mbus.in_valid = 1'b0; mbus.a = '0; mbus.b = '0; mbus.mode = 1'b0;
      mbus.poly = '0; mbus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_in_ready", 128'(mbus.in_ready), 128'd1);
      chk_eq("rst_out_valid", 128'(mbus.out_valid), 128'd0);
      chk_eq("rst_y", 128'(mbus.y), 128'd0);
      rst = 1'b0; sw_rst = 1'b0;

      send(8'h03, 8'h03, 1'b0, 8'h00, 128'h0005); wait_res();
      send(8'hFF, 8'hFF, 1'b0, 8'h00, 128'h5555); wait_res();
      send(8'h57, 8'h83, 1'b1, 8'h1B, 128'h00C1); wait_res();
      send(8'h57, 8'h13, 1'b1, 8'h1B, 128'h00FE); wait_res();
      send(8'h00, 8'hA5, 1'b0, 8'h00, 128'h0); wait_res();
      send(8'hA5, 8'h00, 1'b1, 8'h1B, 128'h0); wait_res();
      send(8'h57, 8'h83, 1'b1, 8'h00, ref_f(64'h57, 64'h83, 64'h0, W, 1'b0) & 128'hFF);
      wait_res();

      for (int t = 0; t < 1000; t++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         send_ref(ra, rb, 1'b0, 8'h00);
      end
      for (int t = 0; t < 200; t++) begin
         ra = 8'($urandom); rb = 8'($urandom); rp = 8'($urandom);
         send_ref(ra, rb, 1'b1, rp);
      end

      // Stall in DONE while the request side keeps poking the block.
      mbus.out_ready = 1'b0;
      send(8'h57, 8'h83, 1'b1, 8'h1B, 128'h00C1);
      n = 0;
      while (!mbus.out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      for (int t = 0; t < 10; t++) begin
         mbus.in_valid = ~mbus.in_valid;
         mbus.a = 8'($urandom);
         @(negedge clk);
         chk_eq("hold_y", 128'(mbus.y), 128'h00C1);
         chk_eq("hold_in_ready", 128'(mbus.in_ready), 128'd0);
         chk_eq("hold_out_valid", 128'(mbus.out_valid), 128'd1);
         @(posedge clk); #1;
      end
      mbus.in_valid = 1'b0; mbus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk_eq("release_in_ready", 128'(mbus.in_ready), 128'd1);
      chk_eq("release_out_valid", 128'(mbus.out_valid), 128'd0);
      chk_eq("release_popped", 128'(exp_q.size()), 128'd0);
      for (int t = 0; t < 6; t++) begin
         @(posedge clk); #1;
         chk_eq("no_extra_accept", 128'(mbus.out_valid), 128'd0);
      end

      // Reset during the second BUSY cycle.
      send(8'hC3, 8'h5A, 1'b0, 8'h00, 128'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      chk_eq("busy_rst_in_ready", 128'(mbus.in_ready), 128'd1);
      chk_eq("busy_rst_y", 128'(mbus.y), 128'd0);
      for (int t = 0; t < 8; t++) begin
         chk_eq("busy_rst_no_out", 128'(mbus.out_valid), 128'd0);
         @(posedge clk); #1;
      end
      send_ref(8'hC3, 8'h5A, 1'b1, 8'h1B);

      // in_valid on a reset edge must be dropped.
      mbus.a = 8'h12; mbus.b = 8'h34; mbus.mode = 1'b0; mbus.in_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      mbus.in_valid = 1'b0; rst = 1'b0;
      for (int t = 0; t < CYC + 3; t++) begin
         chk_eq("rst_edge_no_accept", 128'(mbus.out_valid), 128'd0);
         @(posedge clk); #1;
      end
      send_ref(8'h12, 8'h34, 1'b0, 8'h00);

      n = 0;
      while (!(g_sw[0].done_b && g_sw[1].done_b && g_sw[2].done_b && g_sw[3].done_b &&
               g_sw[4].done_b && g_sw[5].done_b && g_sw[6].done_b && g_sw[7].done_b) &&
             n < 20000) begin
         @(posedge clk); n++;
      end
      if (n >= 20000) chk_eq("sweep_timeout", 128'd1, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
